// File: rtl/lcd_init_sequencer.sv
// Drives a 4-bit HD44780 writer. It runs the power-on init once after reset,
// then writes up to 10 characters to line 1 for each accepted start request.
module lcd_init_sequencer #(
  parameter int unsigned WAIT_PWR   = 750000,
  parameter int unsigned WAIT_4MS   = 205000,
  parameter int unsigned WAIT_100US = 5000,
  parameter int unsigned WAIT_CMD   = 2000,
  parameter int unsigned WAIT_CLR   = 82000,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iStart,
  input  logic [79:0] iPhrase,
  input  logic        iWriter_Done,
  output logic        oWriter_Go,
  output logic [1:0]  oWriter_Mode,
  output logic [7:0]  oWriter_Byte,
  output logic        oLCD_RS,
  output logic        oLCD_RW,
  output logic        oReady,
  output logic        oPhrase_Done,
  output logic        oError
);

  typedef enum logic [2:0] {
    S_PWR_WAIT, S_ISSUE, S_WAIT_DONE, S_DELAY, S_IDLE, S_CHAR, S_DONE
  } state_t;

  // Steps 0..7 are the init commands, then the DDRAM address set, then characters.
  localparam logic [3:0] STEP_CLR  = 4'd7;
  localparam logic [3:0] STEP_ADDR = 4'd8;
  localparam logic [3:0] STEP_CHAR = 4'd9;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [79:0] phrase_q, phrase_d;
  logic        go_q, go_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        ready_q, ready_d;
  logic        pdone_q, pdone_d;
  logic        error_q, error_d;
  logic [7:0]  cur_char;

  function automatic logic [9:0] init_cmd(input logic [3:0] s);
    case (s)
      4'd0, 4'd1, 4'd2: return {2'd0, 8'h03};
      4'd3:             return {2'd0, 8'h02};
      4'd4:             return {2'd1, 8'h28};
      4'd5:             return {2'd1, 8'h06};
      4'd6:             return {2'd1, 8'h0C};
      default:          return {2'd1, 8'h01};
    endcase
  endfunction

  function automatic logic [31:0] step_delay(input logic [3:0] s);
    case (s)
      4'd0:             return WAIT_4MS;
      4'd1, 4'd2, 4'd3: return WAIT_100US;
      STEP_CLR:         return WAIT_CLR;
      default:          return WAIT_CMD;
    endcase
  endfunction

  assign cur_char = 8'(phrase_q >> {idx_q, 3'b000});

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 32'd1;
    phrase_d = phrase_q;
    mode_d   = mode_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    error_d  = error_q;
    case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == WAIT_PWR - 32'd1) begin
          step_d            = '0;
          {mode_d, byte_d}  = init_cmd(4'd0);
          rs_d              = 1'b0;
          state_d           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (iWriter_Done) begin
          cnt_d   = '0;
          state_d = S_DELAY;
        end else if (cnt_q == TIMEOUT - 32'd1) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DELAY: begin
        if (cnt_q == step_delay(step_q) - 32'd1) begin
          if (step_q < STEP_CLR) begin
            step_d           = step_q + 4'd1;
            {mode_d, byte_d} = init_cmd(step_q + 4'd1);
            rs_d             = 1'b0;
            state_d          = S_ISSUE;
          end else if (step_q == STEP_CLR) begin
            state_d = S_IDLE;
          end else if (step_q == STEP_ADDR) begin
            idx_d   = '0;
            state_d = S_CHAR;
          end else if (idx_q == 4'd9) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_CHAR;
          end
        end
      end
      S_IDLE: begin
        if (iStart) begin
          phrase_d = iPhrase;
          idx_d    = '0;
          step_d   = STEP_ADDR;
          mode_d   = 2'd1;
          byte_d   = 8'h80;
          rs_d     = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_CHAR: begin
        if (cur_char == 8'h00) begin
          state_d = S_DONE;
        end else begin
          step_d  = STEP_CHAR;
          mode_d  = 2'd1;
          byte_d  = cur_char;
          rs_d    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_PWR_WAIT;
    endcase
    // Status flags are registered copies of the next state so they align with it.
    go_d    = (state_d == S_ISSUE);
    ready_d = (state_d == S_IDLE);
    pdone_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= S_PWR_WAIT;
      step_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      phrase_q <= '0;
      go_q     <= 1'b0;
      mode_q   <= '0;
      byte_q   <= '0;
      rs_q     <= 1'b0;
      ready_q  <= 1'b0;
      pdone_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      phrase_q <= phrase_d;
      go_q     <= go_d;
      mode_q   <= mode_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
      ready_q  <= ready_d;
      pdone_q  <= pdone_d;
      error_q  <= error_d;
    end
  end

  assign oWriter_Go   = go_q;
  assign oWriter_Mode = mode_q;
  assign oWriter_Byte = byte_q;
  assign oLCD_RS      = rs_q;
  assign oLCD_RW      = 1'b0;
  assign oReady       = ready_q;
  assign oPhrase_Done = pdone_q;
  assign oError       = error_q;

endmodule
